// File: rtl/wb_pkg.sv
// Shared Wishbone constants, bus word types and slave FSM state encoding.
// Imported by if_wb and by the pipelined slave and its RAM.
package wb_pkg;

  localparam int adr_width = 16;
  localparam int dat_width = 16;

  typedef logic [adr_width-1:0] adr_t;
  typedef logic [dat_width-1:0] dat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } wb_state_e;

  // Width of the wait counter: ceil(log2(waitcycles+1)), never narrower than 1 bit.
  function automatic int cnt_width(input int waitcycles);
    return (waitcycles < 1) ? 1 : $clog2(waitcycles + 1);
  endfunction

endpackage

// File: rtl/wb_slave_pipelined_if.sv
// Wishbone B4 pipelined bus bundle (if_wb) with master and slave views.
interface if_wb;
  import wb_pkg::*;

  logic cyc;
  logic stb;
  logic we;
  adr_t adr;
  dat_t dat_m;
  dat_t dat_s;
  logic ack;
  logic stall;

  modport master (output cyc, stb, we, adr, dat_m, input dat_s, ack, stall);
  modport slave  (input cyc, stb, we, adr, dat_m, output dat_s, ack, stall);

endinterface

// File: rtl/wb_slave_ram.sv
// Single-port synchronous RAM: write on we_i, registered read on re_i.
// Contents and read register are deliberately not reset.
module wb_slave_ram
  import wb_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  dat_t              wdata_i,
  output dat_t              rdata_o
);

  dat_t mem_q [DEPTH];
  dat_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_slave_pipelined.sv
// Wishbone B4 pipelined memory slave: one request in flight, waitcycles stall cycles per request.
// Define WB_SLAVE_ASSERT_EN to compile the protocol assertions.
module wb_slave_pipelined
  import wb_pkg::*;
#(
  parameter int waitcycles = 0,
  parameter int mem_depth  = 256
) (
  input logic clk,
  input logic rst,
  if_wb.slave wb
);

  localparam int CNT_W  = cnt_width(waitcycles);
  localparam int MEM_AW = $clog2(mem_depth);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((waitcycles > 0) ? (waitcycles - 1) : 0);

  wb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  dat_t             dat_s_q, dat_s_d;
  dat_t             ram_rdata;
  logic             accept, ack, stall, rd_ack;
  logic             unused_adr_hi;

  assign stall  = (state_q == ST_WAIT);
  // Gating with cyc keeps ack low in a cycle where the master has abandoned the bus.
  assign ack    = (state_q == ST_ACK) && wb.cyc;
  assign rd_ack = ack && !we_q;
  assign accept = wb.cyc && wb.stb && !stall && !rst;

  assign unused_adr_hi = ^wb.adr[adr_width-1:MEM_AW];

  wb_slave_ram #(
    .DEPTH (mem_depth)
  ) u_ram (
    .clk     (clk),
    .we_i    (accept && wb.we),
    .re_i    (accept && !wb.we),
    .addr_i  (wb.adr[MEM_AW-1:0]),
    .wdata_i (wb.dat_m),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    dat_s_d = dat_s_q;
    if (rd_ack) begin
      dat_s_d = ram_rdata;
    end
    if (!wb.cyc) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_d = ST_ACK;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (accept) begin
        we_d    = wb.we;
        cnt_d   = CNT_LOAD;
        state_d = (waitcycles == 0) ? ST_ACK : ST_WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      dat_s_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      dat_s_q <= dat_s_d;
    end
  end

  // Read data is forwarded straight from the RAM register in the ack cycle, then held.
  assign wb.dat_s = rd_ack ? ram_rdata : dat_s_q;
  assign wb.ack   = ack;
  assign wb.stall = stall;

`ifdef WB_SLAVE_ASSERT_EN
  logic acc_seen_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_seen_q <= 1'b0;
    end else if (accept) begin
      acc_seen_q <= 1'b1;
    end else if (ack || !wb.cyc) begin
      acc_seen_q <= 1'b0;
    end
  end

  a_ack_cyc: assert property (@(posedge clk) disable iff (rst) ack |-> wb.cyc);
  a_ack_acc: assert property (@(posedge clk) disable iff (rst) ack |-> acc_seen_q);
  a_no_stall: assert property (@(posedge clk) disable iff (rst) (waitcycles == 0) |-> !stall);
  a_ack_gap: assert property (@(posedge clk) disable iff (rst) ((waitcycles > 0) && ack) |=> !ack);
  a_dat_known: assert property (@(posedge clk) disable iff (rst) rd_ack |-> !$isunknown(wb.dat_s));
`endif

endmodule

// File: tb/tb_wb_slave_pipelined.sv
// Self-checking bench: a waitcycles=0 and a waitcycles=3 slave checked every cycle against a timestamp model.
module tb_wb_slave_pipelined;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  if_wb wb0 ();
  if_wb wb3 ();

  wb_slave_pipelined #(.waitcycles(0), .mem_depth(256)) u_w0 (.clk(clk), .rst(rst), .wb(wb0));
  wb_slave_pipelined #(.waitcycles(3), .mem_depth(256)) u_w3 (.clk(clk), .rst(rst), .wb(wb3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state per instance (index 0: waitcycles=0, index 1: waitcycles=3)
  int          c = 0;
  bit          chk_en = 1'b0;
  bit          pend [2];
  int          ack_at [2];
  bit          pend_we [2];
  logic [15:0] pend_rd [2];
  logic [15:0] last_dat [2];
  int          acc_cnt [2];
  int          dut_acks [2];
  logic [15:0] mem_m [2][256];

  function automatic int wt(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic logic [34:0] ins(input int i);
    if (i == 0) return {wb0.cyc, wb0.stb, wb0.we, wb0.adr, wb0.dat_m};
    return {wb3.cyc, wb3.stb, wb3.we, wb3.adr, wb3.dat_m};
  endfunction

  function automatic logic [17:0] outs(input int i);
    if (i == 0) return {wb0.ack, wb0.stall, wb0.dat_s};
    return {wb3.ack, wb3.stall, wb3.dat_s};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s at cycle %0d: got %h, expected %h", name, c, act, exp);
    end
  endtask

  task automatic drive(input int i, input bit cy, input bit st, input bit w,
                       input logic [15:0] a, input logic [15:0] d);
    if (i == 0) begin
      wb0.cyc = cy; wb0.stb = st; wb0.we = w; wb0.adr = a; wb0.dat_m = d;
    end else begin
      wb3.cyc = cy; wb3.stb = st; wb3.we = w; wb3.adr = a; wb3.dat_m = d;
    end
  endtask

  // Model: a request accepted at edge k acks in cycle k+W+1 and stalls the cycles in between.
  logic [34:0] m_in;
  bit          m_stl;
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_in  = ins(i);
      m_stl = pend[i] && (c < ack_at[i]);
      if (rst) begin
        pend[i]     = 1'b0;
        last_dat[i] = '0;
        chk_en      = 1'b1;
      end else begin
        if (pend[i] && (!m_in[34] || c == ack_at[i])) begin
          if (m_in[34] && !pend_we[i]) last_dat[i] = pend_rd[i];
          pend[i] = 1'b0;
        end
        if (m_in[34] && m_in[33] && !m_stl) begin
          acc_cnt[i]++;
          if (m_in[32]) mem_m[i][m_in[23:16]] = m_in[15:0];
          else          pend_rd[i] = mem_m[i][m_in[23:16]];
          pend_we[i] = m_in[32];
          pend[i]    = 1'b1;
          ack_at[i]  = c + wt(i) + 1;
        end
      end
    end
    c++;
  end

  logic [34:0] k_in;
  logic [17:0] k_out;
  bit          e_ack, e_stall;
  logic [15:0] e_dat;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        k_in    = ins(i);
        k_out   = outs(i);
        e_stall = pend[i] && (c < ack_at[i]);
        e_ack   = pend[i] && (c == ack_at[i]) && k_in[34];
        e_dat   = (e_ack && !pend_we[i]) ? pend_rd[i] : last_dat[i];
        chk((i == 0) ? "w0_ack" : "w3_ack", k_out[17], e_ack);
        chk((i == 0) ? "w0_stall" : "w3_stall", k_out[16], e_stall);
        chk((i == 0) ? "w0_dat_s" : "w3_dat_s", k_out[15:0], e_dat);
        if (k_out[17] === 1'b1) dut_acks[i]++;
      end
    end
  end

  task automatic wait_acc(input int i, input int n0);
    int k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (acc_cnt[i] == n0 && k < 40);
    if (acc_cnt[i] == n0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic single(input int i, input bit w, input logic [15:0] a, input logic [15:0] d,
                        input bit lit, input logic [15:0] exp);
    int n0 = acc_cnt[i];
    logic [17:0] o;
    drive(i, 1'b1, 1'b1, w, a, d);
    wait_acc(i, n0);
    drive(i, 1'b1, 1'b0, w, a, d);
    repeat (wt(i)) @(posedge clk);
    @(negedge clk);
    o = outs(i);
    chk("single_ack", {31'd0, o[17]}, 32'd1);
    if (lit) chk("single_dat", {16'd0, o[15:0]}, {16'd0, exp});
    @(posedge clk); #1;
    drive(i, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [17:0] o;
    int n0, a0;
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [17:0] o;
    int n0, a0;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      o = outs(i);
      chk("reset_state", {14'd0, o}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Single writes then single reads, waitcycles=0
    for (int j = 1; j <= 10; j++) single(0, 1'b1, 16'(j), 16'(100 + j), 1'b0, '0);
    for (int j = 1; j <= 10; j++) single(0, 1'b0, 16'(j), '0, 1'b1, 16'(100 + j));

    // stb without cyc must not write
    drive(0, 1'b0, 1'b1, 1'b1, 16'd7, 16'h7777);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    single(0, 1'b0, 16'd7, '0, 1'b1, 16'd107);

    // Back-to-back stream, waitcycles=0
    for (int j = 0; j < 21; j++) begin
      if (j < 20) drive(0, 1'b1, 1'b1, j < 10, 16'(11 + j % 10), 16'(211 + j % 10));
      else        drive(0, 1'b1, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      o = outs(0);
      chk("b2b_stall", {31'd0, o[16]}, 32'd0);
      if (j > 0)  chk("b2b_ack", {31'd0, o[17]}, 32'd1);
      if (j > 10) chk("b2b_dat", {16'd0, o[15:0]}, 32'(211 + j - 11));
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Back-to-back stream, waitcycles=3: stb held, next item presented right after each accept
    a0 = dut_acks[1];
    for (int j = 0; j < 10; j++) begin
      n0 = acc_cnt[1];
      drive(1, 1'b1, 1'b1, j < 5, 16'(30 + j % 5), 16'(16'h0300 + j % 5));
      wait_acc(1, n0);
    end
    drive(1, 1'b1, 1'b0, 1'b0, '0, '0);
    repeat (4) @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("w3_ack_count", 32'(dut_acks[1] - a0), 32'd10);
    o = outs(1);
    chk("w3_last_dat", {16'd0, o[15:0]}, 32'h0304);

    // Abort: cyc dropped in the cycle after a read accept
    a0 = dut_acks[1];
    n0 = acc_cnt[1];
    drive(1, 1'b1, 1'b1, 1'b0, 16'd31, '0);
    wait_acc(1, n0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    o = outs(1);
    chk("abort_stall", {31'd0, o[16]}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_ack", 32'(dut_acks[1] - a0), 32'd0);
    single(1, 1'b0, 16'd32, '0, 1'b1, 16'h0302);

    // Reset mid-transfer on the waitcycles=3 slave; a write presented during reset is dropped
    n0 = acc_cnt[1];
    drive(1, 1'b1, 1'b1, 1'b0, 16'd30, '0);
    wait_acc(1, n0);
    drive(1, 1'b1, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 1'b1, 1'b1, 1'b1, 16'd5, 16'hDEAD);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      o = outs(i);
      chk("rst_mid_state", {14'd0, o}, 32'd0);
    end
    a0 = dut_acks[1];
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_ack", 32'(dut_acks[1] - a0), 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;

    single(0, 1'b0, 16'd5, '0, 1'b1, 16'd105);
    single(0, 1'b1, 16'd300, 16'hBEEF, 1'b0, '0);
    single(0, 1'b0, 16'd44, '0, 1'b1, 16'hBEEF);
    single(1, 1'b1, 16'd300, 16'hBEEF, 1'b0, '0);
    single(1, 1'b0, 16'd44, '0, 1'b1, 16'hBEEF);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
